// File: rtl/audio_voice_mixer_pkg.sv
// audio_voice_mixer_pkg: shared mixer defaults, saturation limits and FSM state encoding
package audio_voice_mixer_pkg;
  localparam int NUM_VOICES = 8;
  localparam int IDX_W = 3;
  localparam int GAIN_W = 8;
  localparam int OUT_SHIFT = 8;
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, SAT, DONE, HOLD} state_t;
endpackage

// File: rtl/audio_voice_mixer_if.sv
// audio_voice_mixer_if: voice-table read bus between the mixer (master) and the voice table (slave)
interface audio_voice_mixer_if #(
  parameter int IDX_W = audio_voice_mixer_pkg::IDX_W,
  parameter int GAIN_W = audio_voice_mixer_pkg::GAIN_W
);
  logic rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic signed [15:0] sample;
  logic [GAIN_W-1:0] gain_l;
  logic [GAIN_W-1:0] gain_r;
  logic voice_en;
  modport master(output rd_en, rd_idx, input sample, gain_l, gain_r, voice_en);
  modport slave(input rd_en, rd_idx, output sample, gain_l, gain_r, voice_en);
endinterface

// File: rtl/audio_mac_sat.sv
// audio_mac_sat: one channel's gain multiply-accumulate, arithmetic shift and 16-bit saturation with sticky clip
module audio_mac_sat #(
  parameter int GAIN_W = audio_voice_mixer_pkg::GAIN_W,
  parameter int IDX_W = audio_voice_mixer_pkg::IDX_W,
  parameter int OUT_SHIFT = audio_voice_mixer_pkg::OUT_SHIFT
) (
  input  logic iCLK,
  input  logic AUD_DACLRCK,
  input  logic i_acc_en,
  input  logic i_sat_en,
  input  logic i_mute,
  input  logic i_voice_en,
  input  logic signed [15:0] i_sample,
  input  logic [GAIN_W-1:0] i_gain,
  output logic [15:0] o_mix,
  output logic o_clip
);
  import audio_voice_mixer_pkg::*;
  localparam int PROD_W = 16 + GAIN_W + 1;
  localparam int ACC_W = PROD_W + IDX_W;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d, t;
  logic [15:0] mix_q, mix_d;
  logic clip_q, clip_d, pos_ovf, neg_ovf;
  always_comb begin
    prod = PROD_W'(i_sample) * PROD_W'($signed({1'b0, i_gain}));
    acc_d = (i_acc_en && i_voice_en) ? acc_q + {{IDX_W{prod[PROD_W-1]}}, prod} : acc_q;
    t = acc_q >>> OUT_SHIFT;
    // in range only when every bit above bit 15 matches the sign
    pos_ovf = !t[ACC_W-1] && |t[ACC_W-2:15];
    neg_ovf = t[ACC_W-1] && !(&t[ACC_W-2:15]);
    mix_d = !i_sat_en ? mix_q : i_mute ? 16'h0000 : pos_ovf ? SAT_MAX : neg_ovf ? SAT_MIN : t[15:0];
    clip_d = clip_q | (i_sat_en & ~i_mute & (pos_ovf | neg_ovf));
  end
  always_ff @(posedge iCLK or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      acc_q <= '0;
      mix_q <= '0;
      clip_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mix_q <= mix_d;
      clip_q <= clip_d;
    end
  end
  assign o_mix = mix_q;
  assign o_clip = clip_q;
endmodule

// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer: one-shot per-LRCK-high scan of the voice table into saturated stereo mix
// LRCK low is the reset; the scan runs once per high half and parks in HOLD.
module audio_voice_mixer #(
  parameter int NUM_VOICES = audio_voice_mixer_pkg::NUM_VOICES,
  parameter int IDX_W = audio_voice_mixer_pkg::IDX_W,
  parameter int GAIN_W = audio_voice_mixer_pkg::GAIN_W,
  parameter int OUT_SHIFT = audio_voice_mixer_pkg::OUT_SHIFT
) (
  input  logic iCLK,
  input  logic AUD_DACLRCK,
  audio_voice_mixer_if.master vb,
  input  logic i_mute,
  output logic [15:0] o_mixL,
  output logic [15:0] o_mixR,
  output logic o_done,
  output logic o_busy,
  output logic o_clipL,
  output logic o_clipR
);
  import audio_voice_mixer_pkg::*;
  state_t state_q, state_d;
  logic rd_en_q, rd_en_d, done_q, done_d, busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    idx_d = idx_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        rd_en_d = 1'b1;
        idx_d = '0;
      end
      RUN: begin
        state_d = (idx_q == IDX_W'(NUM_VOICES - 1)) ? DRAIN : RUN;
        rd_en_d = idx_q != IDX_W'(NUM_VOICES - 1);
        idx_d = (idx_q == IDX_W'(NUM_VOICES - 1)) ? idx_q : idx_q + 1'b1;
      end
      DRAIN: state_d = SAT;
      SAT: begin
        state_d = DONE;
        done_d = 1'b1;
      end
      DONE: state_d = HOLD;
      default: state_d = state_q;
    endcase
    busy_d = state_d inside {RUN, DRAIN, SAT};
  end
  always_ff @(posedge iCLK or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      idx_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      idx_q <= idx_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign vb.rd_en = rd_en_q;
  assign vb.rd_idx = idx_q;
  assign o_done = done_q;
  assign o_busy = busy_q;
  // data for a read strobe arrives the following cycle, so rd_en_q gates accumulation
  audio_mac_sat #(.GAIN_W(GAIN_W), .IDX_W(IDX_W), .OUT_SHIFT(OUT_SHIFT)) u_mac_l (
    .iCLK(iCLK), .AUD_DACLRCK(AUD_DACLRCK), .i_acc_en(rd_en_q), .i_sat_en(state_q == SAT),
    .i_mute(i_mute), .i_voice_en(vb.voice_en), .i_sample(vb.sample), .i_gain(vb.gain_l),
    .o_mix(o_mixL), .o_clip(o_clipL)
  );
  audio_mac_sat #(.GAIN_W(GAIN_W), .IDX_W(IDX_W), .OUT_SHIFT(OUT_SHIFT)) u_mac_r (
    .iCLK(iCLK), .AUD_DACLRCK(AUD_DACLRCK), .i_acc_en(rd_en_q), .i_sat_en(state_q == SAT),
    .i_mute(i_mute), .i_voice_en(vb.voice_en), .i_sample(vb.sample), .i_gain(vb.gain_r),
    .o_mix(o_mixR), .o_clip(o_clipR)
  );
endmodule

// File: tb/tb_audio_voice_mixer.sv
// tb_audio_voice_mixer: directed frames against hand-computed mix results, timing and reset behaviour
module tb_audio_voice_mixer;
  logic iclk = 1'b0, lrck = 1'b0, mute = 1'b0;
  logic [15:0] mix_l, mix_r;
  logic done, busy, clip_l, clip_r;
  int total = 0, bad = 0;
  logic signed [15:0] samp [8];
  logic [7:0] gl [8], gr [8];
  logic en [8];
  int done_cnt, done_cyc, idx_err;
  logic [31:0] busy_m, rd_m;

  audio_voice_mixer_if vb();
  audio_voice_mixer dut (
    .iCLK(iclk), .AUD_DACLRCK(lrck), .vb(vb), .i_mute(mute),
    .o_mixL(mix_l), .o_mixR(mix_r), .o_done(done), .o_busy(busy),
    .o_clipL(clip_l), .o_clipR(clip_r)
  );

  always #5 iclk = ~iclk;

  // voice table: answers a read one cycle later, drives junk when not read
  always @(posedge iclk) begin
    #1;
    if (vb.rd_en) begin
      vb.sample = samp[vb.rd_idx];
      vb.gain_l = gl[vb.rd_idx];
      vb.gain_r = gr[vb.rd_idx];
      vb.voice_en = en[vb.rd_idx];
    end else begin
      vb.sample = 16'h5A5A;
      vb.gain_l = 8'd255;
      vb.gain_r = 8'd255;
      vb.voice_en = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] s, input logic [7:0] a, input logic [7:0] b, input logic e);
    for (int i = 0; i < 8; i++) begin
      samp[i] = s;
      gl[i] = a;
      gr[i] = b;
      en[i] = e;
    end
  endtask

  task automatic test1_data();
    set_all(16'd3000, 8'd255, 8'd255, 1'b0);
    samp[0] = 16'd1000;
    en[0] = 1'b1;
  endtask

  task automatic frame(input int n);
    done_cnt = 0; done_cyc = -1; idx_err = 0; busy_m = '0; rd_m = '0;
    @(negedge iclk) lrck = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge iclk);
      #2;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c < 32) begin
        busy_m[c] = busy;
        rd_m[c] = vb.rd_en;
      end
      if (vb.rd_en && vb.rd_idx != 3'(c - 1)) idx_err++;
    end
  endtask

  task automatic rst_low();
    @(negedge iclk) lrck = 1'b0;
    @(negedge iclk);
  endtask

  initial begin
    set_all(16'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(posedge iclk);
    #2;
    chk("rst_rd_en", 32'(vb.rd_en), 0);
    chk("rst_rd_idx", 32'(vb.rd_idx), 0);
    chk("rst_mix", {mix_l, mix_r}, 0);
    chk("rst_flags", {done, busy, clip_l, clip_r}, 0);

    test1_data();
    frame(20);
    chk("t1_done_cyc", done_cyc, 11);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_mix_l", 32'(mix_l), 32'h03E4);
    chk("t1_mix_r", 32'(mix_r), 32'h03E4);
    chk("t1_clips", {clip_l, clip_r}, 0);
    chk("t1_busy_mask", busy_m, 32'h0000_07FE);
    chk("t1_rd_mask", rd_m, 32'h0000_01FE);
    chk("t1_idx_seq", idx_err, 0);
    rst_low();

    set_all(16'h7FFF, 8'd255, 8'd0, 1'b1);
    frame(16);
    chk("t2_mix_l", 32'(mix_l), 32'h7FFF);
    chk("t2_clip_l", 32'(clip_l), 1);
    chk("t2_mix_r", 32'(mix_r), 0);
    chk("t2_clip_r", 32'(clip_r), 0);
    rst_low();
    chk("t2_clip_cleared", 32'(clip_l), 0);

    set_all(16'h8000, 8'd255, 8'd1, 1'b1);
    frame(16);
    chk("t3_mix_l", 32'(mix_l), 32'h8000);
    chk("t3_clip_l", 32'(clip_l), 1);
    chk("t3_mix_r", 32'(mix_r), 32'hFC00);
    chk("t3_clip_r", 32'(clip_r), 0);
    rst_low();

    set_all(16'd1234, 8'd128, 8'd0, 1'b0);
    samp[3] = -16'sd500;
    en[3] = 1'b1;
    frame(16);
    chk("t3b_mix_l", 32'(mix_l), 32'hFF06);
    chk("t3b_mix_r", 32'(mix_r), 0);
    chk("t3b_clip_l", 32'(clip_l), 0);
    rst_low();

    test1_data();
    @(negedge iclk) lrck = 1'b1;
    repeat (5) @(posedge iclk);
    #1;
    chk("t4_busy_before", 32'(busy), 1);
    lrck = 1'b0;
    #1;
    chk("t4_abort_ctl", {vb.rd_en, busy, done}, 0);
    chk("t4_abort_idx", 32'(vb.rd_idx), 0);
    chk("t4_abort_mix", {mix_l, mix_r}, 0);
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge iclk);
      #2;
      if (done) done_cnt++;
    end
    chk("t4_no_done", done_cnt, 0);
    frame(20);
    chk("t4_redo_done", done_cnt, 1);
    chk("t4_redo_cyc", done_cyc, 11);
    chk("t4_redo_mix", {mix_l, mix_r}, {16'h03E4, 16'h03E4});
    rst_low();

    set_all(16'h7FFF, 8'd255, 8'd255, 1'b1);
    mute = 1'b1;
    frame(16);
    chk("t5_mix", {mix_l, mix_r}, 0);
    chk("t5_clips", {clip_l, clip_r}, 0);
    chk("t5_done_cnt", done_cnt, 1);
    mute = 1'b0;
    rst_low();

    test1_data();
    frame(600);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_idx_seq", idx_err, 0);
    chk("t6_mix_l", 32'(mix_l), 32'h03E4);
    rst_low();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
